// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_stream_loader
// Description : Writer side of the instruction-memory interface. Takes a
//               byte stream over a valid/ready handshake, assembles
//               big-endian 32-bit words and writes them to consecutive
//               instruction-memory word addresses. The processor core is
//               held in reset while loading and released when done.
//
//               Stream format: 4-byte header N (word count), then N
//               words of 4 bytes each. With CHECKSUM_EN, 4 more bytes C
//               follow; C must equal the 32-bit wrap-around sum of N and
//               all N words.
//
// Optional    : `define CHECKSUM_EN enables the trailing checksum check.
//
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous reset, active low
//               in_data    - stream byte
//               in_valid   - in_data valid
//               in_ready   - loader can accept a byte
//               reload     - single-cycle restart request (RUN only)
//               imem_we    - instruction-memory write enable (1-cycle pulse)
//               imem_addr  - word address of the write
//               imem_wdata - instruction word being written
//               cpu_hold   - active-high hold-in-reset to the core
//               done       - program loaded, core running
//               error      - load aborted
//               word_cnt   - words written in the current load
//
// Revision    : 1.0 - initial release
// ============================================================================
module imem_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
`ifdef CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_ERR  = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;      // byte position within current word
  logic [23:0]       asm_q, asm_d;        // first three bytes of current word
  logic [ADDR_W:0]   n_q, n_d;            // header word count
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
`ifdef CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_inc;

  // Ready depends only on state and reset, never on in_valid.
  assign w_ready   = rst && ((state_q == S_HDR) || (state_q == S_LOAD)
`ifdef CHECKSUM_EN
                             || (state_q == S_CHK)
`endif
                            );
  assign in_ready  = w_ready;
  assign w_accept  = in_valid && w_ready;
  assign w_last    = (lane_q == 2'd3);
  // Word as it stands once the byte on in_data is taken as the last lane.
  assign w_word    = {asm_q, in_data};
  assign w_cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    n_d      = n_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
`ifdef CHECKSUM_EN
    sum_d    = sum_q;
`endif
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;

    case (state_q)
      S_HDR: begin
        if (w_accept) begin
          asm_d  = w_word[23:0];
          lane_d = lane_q + 2'd1;
          if (w_last) begin
`ifdef CHECKSUM_EN
            sum_d = w_word;
`endif
            if (w_word == 32'd0) begin
`ifdef CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_RUN;
`endif
            end else if (w_word > c_max_words) begin
              state_d = S_ERR;
            end else begin
              n_d     = w_word[ADDR_W:0];
              state_d = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        if (cnt_q == n_q) begin
          // Cycle of the final write pulse: the core stays held for this
          // cycle and is released on the next. A byte offered here is
          // beyond the program and is dropped.
          state_d = S_RUN;
        end else if (w_accept) begin
          asm_d  = w_word[23:0];
          lane_d = lane_q + 2'd1;
          if (w_last) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = w_word;
            cnt_d   = w_cnt_inc;
`ifdef CHECKSUM_EN
            sum_d   = sum_q + w_word;
            // Checksum bytes may arrive while the last write is in flight.
            if (w_cnt_inc == n_q) begin
              state_d = S_CHK;
            end
`endif
          end
        end
      end

`ifdef CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          asm_d  = w_word[23:0];
          lane_d = lane_q + 2'd1;
          if (w_last) begin
            state_d = (w_word == sum_q) ? S_RUN : S_ERR;
          end
        end
      end
`endif

      S_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (reload) begin
          state_d = S_HDR;
          cnt_d   = '0;
          lane_d  = 2'd0;
          asm_d   = '0;
        end
      end

      S_ERR: begin
        error = 1'b1;
      end

      default: begin
        state_d = S_HDR;
      end
    endcase

    // Hold the core and mask status while reset is asserted.
    if (!rst) begin
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HDR;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_stream_loader
// Description : Self-checking bench for imem_stream_loader. Streams are
//               checked against a reference model that derives the expected
//               write list and final status directly from the stream bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_cnt;

  always #5 clk = ~clk;

  imem_stream_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_cnt   (word_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] mon_q[$];   // observed writes {addr, data}
  logic [ADDR_W+31:0] exp_q[$];   // expected writes {addr, data}
  logic [7:0]         stim[$];
  bit                 exp_done;
  bit                 exp_err;
  int                 exp_cnt;
  int                 exp_n;

  always @(negedge clk) begin
    if (imem_we === 1'b1) mon_q.push_back({imem_addr, imem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {stim[i], stim[i+1], stim[i+2], stim[i+3]};
  endfunction

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  // Appends the trailing checksum when the build carries one.
  task automatic finish_stream();
`ifdef CHECKSUM_EN
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < stim.size(); i += 4) s += word_at(i);
    push_word(s);
`endif
  endtask

  // Reference model: header N, then N words to addresses 0..N-1.
  task automatic build_model();
    logic [31:0] n;
    logic [31:0] s;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_cnt  = 0;
    exp_n    = 0;
    n = word_at(0);
    if (n > MAX_WORDS) begin
      exp_err = 1;
    end else begin
      exp_n = int'(n);
      s = n;
      for (int k = 0; k < exp_n; k++) begin
        exp_q.push_back({ADDR_W'(k), word_at(4 + 4*k)});
        s += word_at(4 + 4*k);
      end
      exp_cnt = exp_n;
`ifdef CHECKSUM_EN
      if (word_at(4 + 4*exp_n) == s) exp_done = 1;
      else                           exp_err  = 1;
`else
      exp_done = 1;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) chk("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    reload   = 1'b0;
    #1 chk("rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_in_ready_hdr", in_ready, 1);
  endtask

  // Sends stim, checks each write at the negedge after its 4th byte, then
  // checks the final write list and status against the model.
  task automatic run_stream(input int maxgap, input bit fixed_gap);
    int gap;
    build_model();
    for (int i = 0; i < stim.size(); i++) begin
      gap = fixed_gap ? maxgap : int'($urandom_range(maxgap, 0));
      send_byte(stim[i], gap);
      if (i >= 7 && i < 4 + 4*exp_n && (i % 4) == 3) begin
        chk("we_latency", imem_we, 1);
        chk("we_addr", imem_addr, (i - 4) / 4);
        chk("we_data", imem_wdata, word_at(i - 3));
        chk("we_cnt", word_cnt, (i - 4) / 4 + 1);
      end
    end
`ifndef CHECKSUM_EN
    if (exp_done && exp_n > 0) begin
      chk("hold_during_last_we", cpu_hold, 1);
      @(negedge clk);
      chk("hold_released", cpu_hold, 0);
    end
`endif
    repeat (2) @(negedge clk);
    chk("write_count", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk("write_entry", mon_q[i], exp_q[i]);
    chk("final_done", done, exp_done);
    chk("final_error", error, exp_err);
    chk("final_hold", cpu_hold, !exp_done);
    chk("final_cnt", word_cnt, exp_cnt);
    chk("final_in_ready", in_ready, 0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(negedge clk);

    // Basic contiguous load
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd2); push_word(32'h80800190); push_word(32'h8100012C);
    finish_stream();
    run_stream(0, 1);

    // Reload from RUN, then a 1-word load
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
    chk("reload_hold", cpu_hold, 1);
    chk("reload_done", done, 0);
    chk("reload_cnt", word_cnt, 0);
    mon_q.delete();
    stim.delete();
    push_word(32'd1); push_word(32'h41000180);
    finish_stream();
    run_stream(0, 1);

    // Gapped valid: 3 idle cycles between bytes
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd2); push_word(32'h80800190); push_word(32'h8100012C);
    finish_stream();
    run_stream(3, 1);

    // Oversize header, and reload ignored in ERR
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd257);
    run_stream(0, 1);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_ignores_reload", error, 1);
    chk("err_hold", cpu_hold, 1);

    // Maximum accepted header boundary is not an error: N=MAX_WORDS
    // is covered implicitly by the comparison; use N=0 for the empty case
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd0);
    finish_stream();
    run_stream(0, 1);

    // Reset mid-load discards the partial word
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd2);
    for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_reset();
    stim.delete();
    push_word(32'd1); push_word(32'h00000001);
    finish_stream();
    run_stream(0, 1);

`ifdef CHECKSUM_EN
    // Wrong checksum
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'd1); push_word(32'h00000010); push_word(32'h00000012);
    run_stream(0, 1);
`endif

    // Randomized loads with random gaps
    for (int r = 0; r < 5; r++) begin
      int n;
      do_reset();
      mon_q.delete();
      stim.delete();
      n = int'($urandom_range(6, 1));
      push_word(32'(n));
      for (int k = 0; k < n; k++) push_word($urandom);
      finish_stream();
      run_stream(2, 0);
    end

    // Random oversize header
    do_reset();
    mon_q.delete();
    stim.delete();
    push_word(32'($urandom_range(5000, MAX_WORDS + 1)));
    run_stream(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the processor's instruction-memory interface. The core only reads instruction memory (pc in, inst out); this block fills that memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses while holding the processor in reset, then releases it.
- Sits between the host/UART byte source and the instruction RAM write port in the top-level system.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted program length in words; must be no greater than 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle request to restart loading; honoured only in RUN.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  active-high hold-in-reset to the processor core.
- done  out  1  program loaded; core running.
- error  out  1  load aborted.
- word_cnt  out  ADDR_W+1  words written so far in the current load.

Behaviour:
- Reset: one clock with rst=0 gives state HDR and forces these values: in_ready=0 for that cycle, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, word_cnt=0. The byte-lane counter and the assembly register are cleared.
- A byte is accepted when in_valid and in_ready are both high on a clock edge. in_data is ignored on other edges.
- Byte order: the first byte of each group of four becomes bits [31:24]; the fourth becomes bits [7:0].
- States:
  - HDR
    - in_ready=1.
    - Collects 4 bytes forming N, the word count.
    - N=0 goes to RUN.
    - N>MAX_WORDS goes to ERR.
    - Otherwise goes to LOAD.
  - LOAD
    - in_ready=1.
    - On acceptance of the 4th byte of a word: in the next cycle imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=assembled word; word_cnt increments in that same cycle.
    - Write latency is exactly 1 cycle after the final byte handshake.
    - After the write with word_cnt reaching N, the next state is CHK if CHECKSUM_EN is defined, otherwise RUN.
  - RUN
    - in_ready=0, cpu_hold=0, done=1.
    - cpu_hold falls the cycle after the last imem_we pulse.
    - reload=1 goes to HDR: cpu_hold=1, done=0, word_cnt=0 in the next cycle.
  - ERR
    - in_ready=0, cpu_hold=1, error=1.
    - Exits only through reset.
- Back-to-back bytes are accepted every cycle with no stalls. in_ready never drops inside HDR or LOAD.
- Writes address 0..N-1 in order. No wrap: N≤MAX_WORDS guarantees the address stays in range.
- reload outside RUN is ignored.
- Reset mid-load:
  - Partial word and count are discarded; the loader returns to HDR.
  - Words already written stay in memory; there is no clearing.
  - An imem_we pulse pending in the reset cycle is suppressed.
- imem_wdata and imem_addr hold their last values when imem_we=0.

Optional Feature:
- Macro CHECKSUM_EN.
- When defined:
  - After N words, state CHK collects 4 more bytes, C.
  - The loader keeps a running 32-bit wrap-around sum S of the N header value and all N data words.
  - If C==S, go to RUN; otherwise go to ERR, with the core still held.
  - With N=0, CHK is still entered and C must equal 0.
- When undefined:
  - No CHK state and no checksum bytes are consumed.
  - LOAD goes directly to RUN.

Test Plan:
- Basic load:
  - Stimulus: rst low 1 cycle, then bytes 00 00 00 02 | 80 80 01 90 | 81 00 01 2C, contiguous.
  - Response: imem_we pulses at addr 0 with 0x80800190 and at addr 1 with 0x8100012C, each 1 cycle after its 4th byte. word_cnt=2. cpu_hold falls the next cycle; done=1; in_ready=0.
- Gapped valid:
  - Stimulus: same stream with in_valid low 3 cycles between every byte.
  - Response: identical writes and data; no extra imem_we pulses.
- Oversize and empty headers:
  - Stimulus: header 00 00 01 01 (N=257).
  - Response: ERR, error=1, cpu_hold=1, no writes.
  - Stimulus: header 00 00 00 00.
  - Response: RUN immediately, no writes (CHECKSUM_EN undefined).
- Reset mid-load:
  - Stimulus: after header N=2 plus 2 data bytes, assert rst for 1 cycle, then send a full 1-word load with 0x00000001.
  - Response: the only write is 0x00000001 at addr 0; word_cnt=1; done=1.
- Reload:
  - Stimulus: in RUN, pulse reload, then a 1-word load with 0x4100_0180.
  - Response: cpu_hold=1 and done=0 the cycle after reload. Write at addr 0. RUN is re-entered.
- Checksum (CHECKSUM_EN defined):
  - Stimulus: N=1, word 0x00000010, checksum 0x00000011.
  - Response: RUN.
  - Stimulus: same with checksum 0x00000012.
  - Response: error=1 and cpu_hold=1 held.
